// File: rtl/fixed_point_cmac_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fixed_point_cmac_pkg : shared types and helpers for the complex MAC
// Rev 1.0
// ------------------------------------------------------------------
package fixed_point_cmac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC1 = 3'd1,
        CALC2 = 3'd2,
        CALC3 = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int c_MULTS_AREA = 1;
    localparam int c_MULTS_FAST = 3;

    // Full-precision signed product, arithmetic shift by the fraction width.
    // Callers sign-extend operands to 64 bits and keep the low bits they need.
    function automatic logic [63:0] fxp_mul(input logic signed [63:0] i_a,
                                            input logic signed [63:0] i_b,
                                            input int                 i_d);
        logic signed [127:0] w_p;
        w_p = 128'(i_a) * 128'(i_b);
        w_p = w_p >>> i_d;
        return w_p[63:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_point_complex_mac_complex_product_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// complex_product_unit : 3-mult Karatsuba complex product, 1 or 3 muls
// Rev 1.0
// ------------------------------------------------------------------
module complex_product_unit
    import fixed_point_cmac_pkg::*;
#(
    parameter int N         = 32,
    parameter int D         = 16,
    parameter int NUM_MULTS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_ar,
    input  logic [N-1:0] i_ac,
    input  logic [N-1:0] i_br,
    input  logic [N-1:0] i_bc,
    input  state_t       i_phase,
    output logic [N-1:0] o_pr,
    output logic [N-1:0] o_pc,
    output logic         o_done
);

    logic [N-1:0] w_sa;
    logic [N-1:0] w_sb;

    assign w_sa = i_ar + i_ac;
    assign w_sb = i_br + i_bc;

    generate
        if (N > 64) begin : g_bad_width
            $error("complex_product_unit: N must not exceed 64");
        end

        if (NUM_MULTS == c_MULTS_FAST) begin : g_three
            logic [N-1:0] w_p1;
            logic [N-1:0] w_p2;
            logic [N-1:0] w_p3;
            logic         w_unused_clk_rst;

            assign w_unused_clk_rst = ^{clk, reset};
            assign w_p1   = N'(fxp_mul(64'($signed(i_ar)), 64'($signed(i_br)), D));
            assign w_p2   = N'(fxp_mul(64'($signed(i_ac)), 64'($signed(i_bc)), D));
            assign w_p3   = N'(fxp_mul(64'($signed(w_sa)), 64'($signed(w_sb)), D));
            assign o_pr   = w_p1 - w_p2;
            assign o_pc   = w_p3 - w_p1 - w_p2;
            assign o_done = (i_phase == CALC1);
        end else if (NUM_MULTS == c_MULTS_AREA) begin : g_one
            logic [N-1:0] w_opa;
            logic [N-1:0] w_opb;
            logic [N-1:0] w_m;
            logic [N-1:0] r_p1;
            logic [N-1:0] r_p2;

            // One multiplier walks P1, P2, P3 over CALC1..CALC3.
            always_comb begin
                w_opa = i_ar;
                w_opb = i_br;
                case (i_phase)
                    CALC2: begin
                        w_opa = i_ac;
                        w_opb = i_bc;
                    end
                    CALC3: begin
                        w_opa = w_sa;
                        w_opb = w_sb;
                    end
                    default: ;
                endcase
            end

            assign w_m = N'(fxp_mul(64'($signed(w_opa)), 64'($signed(w_opb)), D));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_p1 <= '0;
                    r_p2 <= '0;
                end else begin
                    if (i_phase == CALC1) r_p1 <= w_m;
                    if (i_phase == CALC2) r_p2 <= w_m;
                end
            end

            assign o_pr   = r_p1 - r_p2;
            assign o_pc   = w_m - r_p1 - r_p2;
            assign o_done = (i_phase == CALC3);
        end else begin : g_bad_mults
            $error("complex_product_unit: NUM_MULTS must be 1 or 3");
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fixed_point_complex_mac.sv
`default_nettype none
// ------------------------------------------------------------------
// fixed_point_complex_mac : grouped fixed-point complex multiply-accumulate
// Rev 1.0
// ------------------------------------------------------------------
module fixed_point_complex_mac
    import fixed_point_cmac_pkg::*;
#(
    parameter int N         = 32,
    parameter int D         = 16,
    parameter int NUM_MULTS = 1,
    parameter int MAX_LEN   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_recv_val,
    output logic                           o_recv_rdy,
    input  logic [N-1:0]                   i_ar,
    input  logic [N-1:0]                   i_ac,
    input  logic [N-1:0]                   i_br,
    input  logic [N-1:0]                   i_bc,
    input  logic                           i_conj,
    input  logic                           i_last,
    input  logic                           i_acc_en,
    output logic                           o_send_val,
    input  logic                           i_send_rdy,
    output logic [N-1:0]                   o_cr,
    output logic [N-1:0]                   o_cc,
    output logic [$clog2(MAX_LEN+1)-1:0]   o_send_len,
    output logic                           o_send_ovf
);

    localparam int LW = $clog2(MAX_LEN + 1);

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_ar, r_ac, r_br, r_bc;
    logic [N-1:0]  r_acc_r, r_acc_c;
    logic [LW-1:0] r_count;
    logic [LW-1:0] w_count_next;
    logic          r_eop;
    logic          r_ovf;
    logic          w_accept;
    logic          w_hit_max;
    logic          w_prod_done;
    logic [N-1:0]  w_pr, w_pc;

    complex_product_unit #(
        .N         (N),
        .D         (D),
        .NUM_MULTS (NUM_MULTS)
    ) u_cpu (
        .clk     (clk),
        .reset   (reset),
        .i_ar    (r_ar),
        .i_ac    (r_ac),
        .i_br    (r_br),
        .i_bc    (r_bc),
        .i_phase (r_state),
        .o_pr    (w_pr),
        .o_pc    (w_pc),
        .o_done  (w_prod_done)
    );

    assign w_accept     = i_recv_val & o_recv_rdy;
    assign w_count_next = r_count + LW'(1);
    assign w_hit_max    = (w_count_next == LW'(MAX_LEN));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC1;
            CALC1:   w_next = w_prod_done ? (r_eop ? DONE : IDLE) : CALC2;
            CALC2:   w_next = CALC3;
            CALC3:   w_next = r_eop ? DONE : IDLE;
            DONE:    if (i_send_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ar    <= '0;
            r_ac    <= '0;
            r_br    <= '0;
            r_bc    <= '0;
            r_eop   <= 1'b0;
            r_ovf   <= 1'b0;
            r_acc_r <= '0;
            r_acc_c <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ar  <= i_ar;
                r_ac  <= i_ac;
                r_br  <= i_br;
                r_bc  <= i_conj ? -i_bc : i_bc;
                r_eop <= i_last | ~i_acc_en | w_hit_max;
                // Overflow only when the length cap, not the caller, closed the group.
                r_ovf <= w_hit_max & ~i_last & i_acc_en;
            end
            if (w_prod_done) begin
                r_acc_r <= r_acc_r + w_pr;
                r_acc_c <= r_acc_c + w_pc;
                r_count <= w_count_next;
            end
            if ((r_state == DONE) && i_send_rdy) begin
                r_acc_r <= '0;
                r_acc_c <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign o_recv_rdy = (r_state == IDLE) && !reset;
    assign o_send_val = (r_state == DONE);
    assign o_cr       = r_acc_r;
    assign o_cc       = r_acc_c;
    assign o_send_len = r_count;
    assign o_send_ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_complex_mac.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fixed_point_complex_mac : directed and randomized checks of the MAC
// Rev 1.0
// ------------------------------------------------------------------
module tb_fixed_point_complex_mac;

    localparam int N         = 32;
    localparam int D         = 16;
    localparam int NUM_MULTS = 1;
    localparam int MAX_LEN   = 4;
    localparam int LW        = $clog2(MAX_LEN + 1);
    localparam int LAT       = (NUM_MULTS == 3) ? 2 : 4;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          recv_val = 1'b0;
    logic          recv_rdy;
    logic [N-1:0]  ar = '0, ac = '0, br = '0, bc = '0;
    logic          cj = 1'b0, lst = 1'b0, ae = 1'b0;
    logic          send_val;
    logic          send_rdy = 1'b0;
    logic [N-1:0]  cr, cc;
    logic [LW-1:0] send_len;
    logic          send_ovf;

    int checks = 0;
    int errors = 0;

    logic [31:0]   m_r, m_c;
    int            m_cnt;

    logic [31:0]   gr, gc;
    logic [LW-1:0] gl;
    logic          go;
    int            lat;

    always #5 clk = ~clk;

    fixed_point_complex_mac #(
        .N(N), .D(D), .NUM_MULTS(NUM_MULTS), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .reset(reset),
        .i_recv_val(recv_val), .o_recv_rdy(recv_rdy),
        .i_ar(ar), .i_ac(ac), .i_br(br), .i_bc(bc),
        .i_conj(cj), .i_last(lst), .i_acc_en(ae),
        .o_send_val(send_val), .i_send_rdy(send_rdy),
        .o_cr(cr), .o_cc(cc), .o_send_len(send_len), .o_send_ovf(send_ovf)
    );

    // Reference: fixed-point product = (a*b) >> D, low 32 bits.
    function automatic logic [31:0] fxm(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> D;
        return p[31:0];
    endfunction

    task automatic model_elem(input logic [31:0] xar, xac, xbr, xbc, input logic xcj, xl, xae,
                              output logic eop, output logic [31:0] er, ec,
                              output int elen, output logic eovf);
        logic [31:0] b2, p1, p2, p3, sa, sb;
        b2 = xcj ? -xbc : xbc;
        sa = xar + xac;
        sb = xbr + b2;
        p1 = fxm(xar, xbr);
        p2 = fxm(xac, b2);
        p3 = fxm(sa, sb);
        m_r = m_r + p1 - p2;
        m_c = m_c + p3 - p1 - p2;
        m_cnt++;
        eop  = xl || !xae || (m_cnt == MAX_LEN);
        eovf = (m_cnt == MAX_LEN) && !xl && xae;
        er   = m_r;
        ec   = m_c;
        elen = m_cnt;
        if (eop) begin
            m_r = '0; m_c = '0; m_cnt = 0;
        end
    endtask

    task automatic send_elem(input logic [31:0] xar, xac, xbr, xbc, input logic xcj, xl, xae);
        int t;
        t = 0;
        @(negedge clk);
        while (!recv_rdy && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: recv_rdy=%0b required 1", recv_rdy);
        end
        ar = xar; ac = xac; br = xbr; bc = xbc; cj = xcj; lst = xl; ae = xae;
        recv_val = 1'b1;
        @(posedge clk); #1;
        recv_val = 1'b0;
    endtask

    task automatic get_result(input int stall, output logic [31:0] r, c,
                              output logic [LW-1:0] len, output logic ovf, output int l);
        int t;
        t = 0;
        @(negedge clk);
        while (!send_val && t < 50) begin @(negedge clk); t++; end
        l = t + 1;
        if (!send_val) begin
            checks++; errors++;
            $display("FAIL result_timeout: send_val=0 required 1");
        end
        r = cr; c = cc; len = send_len; ovf = send_ovf;
        repeat (stall) @(negedge clk);
        send_rdy = 1'b1;
        @(posedge clk); #1;
        send_rdy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({send_val, recv_rdy, cr, cc, send_len, send_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: val=%0b rdy=%0b cr=%h cc=%h len=%0d ovf=%0b required all 0",
                     send_val, recv_rdy, cr, cc, send_len, send_ovf);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        checks++;
        if (recv_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_release_rdy: got %0b required 1", recv_rdy);
        end
    endtask

    task automatic test_plain_mult();
        send_elem(ONE, 2*ONE, 3*ONE, 4*ONE, 1'b0, 1'b0, 1'b0);
        get_result(0, gr, gc, gl, go, lat);
        checks++; if (gr !== 32'hFFFB_0000) begin errors++; $display("FAIL plain_cr: got %h required FFFB0000", gr); end
        checks++; if (gc !== 32'h000A_0000) begin errors++; $display("FAIL plain_cc: got %h required 000A0000", gc); end
        checks++; if (gl !== LW'(1)) begin errors++; $display("FAIL plain_len: got %0d required 1", gl); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL plain_ovf: got %0b required 0", go); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL plain_latency: got %0d required %0d", lat, LAT); end
    endtask

    task automatic test_conj();
        send_elem(ONE, 2*ONE, 3*ONE, 4*ONE, 1'b1, 1'b1, 1'b0);
        get_result(1, gr, gc, gl, go, lat);
        checks++; if (gr !== 32'h000B_0000) begin errors++; $display("FAIL conj_cr: got %h required 000B0000", gr); end
        checks++; if (gc !== 32'h0002_0000) begin errors++; $display("FAIL conj_cc: got %h required 00020000", gc); end
    endtask

    task automatic test_mac();
        int extra;
        send_elem(ONE, ONE, ONE, ONE, 1'b0, 1'b0, 1'b1);
        send_elem(2*ONE, 32'h0, 32'h0000_8000, 32'h0, 1'b0, 1'b1, 1'b1);
        get_result(0, gr, gc, gl, go, lat);
        checks++; if (gr !== ONE) begin errors++; $display("FAIL mac_cr: got %h required 00010000", gr); end
        checks++; if (gc !== 2*ONE) begin errors++; $display("FAIL mac_cc: got %h required 00020000", gc); end
        checks++; if (gl !== LW'(2)) begin errors++; $display("FAIL mac_len: got %0d required 2", gl); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL mac_ovf: got %0b required 0", go); end
        extra = 0;
        repeat (10) begin @(negedge clk); if (send_val) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL mac_single_result: extra valid cycles %0d required 0", extra); end
    endtask

    task automatic test_backpressure();
        int t;
        send_elem(2*ONE, 32'h0, 3*ONE, 32'h0, 1'b0, 1'b0, 1'b0);
        t = 0;
        @(negedge clk);
        while (!send_val && t < 50) begin @(negedge clk); t++; end
        ar = ONE; ac = '0; br = ONE; bc = '0; cj = 1'b0; lst = 1'b1; ae = 1'b1;
        recv_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (send_val !== 1'b1 || cr !== 6*ONE || cc !== 32'h0 || send_len !== LW'(1) || recv_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: val=%0b cr=%h cc=%h len=%0d rdy=%0b required 1 00060000 00000000 1 0",
                         i, send_val, cr, cc, send_len, recv_rdy);
            end
            @(negedge clk);
        end
        recv_val = 1'b0;
        send_rdy = 1'b1;
        @(posedge clk); #1;
        send_rdy = 1'b0;
        send_elem(ONE, 32'h0, ONE, 32'h0, 1'b0, 1'b0, 1'b0);
        get_result(0, gr, gc, gl, go, lat);
        checks++;
        if (gr !== ONE || gc !== 32'h0 || gl !== LW'(1)) begin
            errors++; $display("FAIL stall_next: cr=%h cc=%h len=%0d required 00010000 00000000 1", gr, gc, gl);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            send_elem(ONE, 32'h0, ONE, 32'h0, 1'b0, (i == 5), 1'b1);
            if (i == 3) begin
                get_result(2, gr, gc, gl, go, lat);
                checks++;
                if (gr !== 4*ONE || gl !== LW'(4) || go !== 1'b1) begin
                    errors++; $display("FAIL ovf_first: cr=%h len=%0d ovf=%0b required 00040000 4 1", gr, gl, go);
                end
            end
        end
        get_result(0, gr, gc, gl, go, lat);
        checks++;
        if (gr !== 2*ONE || gl !== LW'(2) || go !== 1'b0) begin
            errors++; $display("FAIL ovf_second: cr=%h len=%0d ovf=%0b required 00020000 2 0", gr, gl, go);
        end
    endtask

    task automatic test_reset_abort();
        int t;
        // Abort mid-calculation with residue already accumulated.
        send_elem(ONE, ONE, ONE, ONE, 1'b0, 1'b0, 1'b1);
        send_elem(ONE, ONE, ONE, ONE, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({send_val, recv_rdy, cr, cc, send_len, send_ovf} !== '0) begin
            errors++; $display("FAIL abort_calc_outputs: val=%0b rdy=%0b cr=%h cc=%h len=%0d required all 0",
                               send_val, recv_rdy, cr, cc, send_len);
        end
        @(negedge clk); reset = 1'b0;
        send_elem(ONE, 2*ONE, 3*ONE, 4*ONE, 1'b0, 1'b0, 1'b0);
        get_result(0, gr, gc, gl, go, lat);
        checks++;
        if (gr !== 32'hFFFB_0000 || gc !== 32'h000A_0000 || gl !== LW'(1)) begin
            errors++; $display("FAIL abort_calc_after: cr=%h cc=%h len=%0d required FFFB0000 000A0000 1", gr, gc, gl);
        end
        // Abort while a result is waiting in DONE.
        send_elem(5*ONE, ONE, ONE, ONE, 1'b0, 1'b1, 1'b1);
        t = 0;
        @(negedge clk);
        while (!send_val && t < 50) begin @(negedge clk); t++; end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({send_val, recv_rdy, cr, cc, send_len, send_ovf} !== '0) begin
            errors++; $display("FAIL abort_done_outputs: val=%0b rdy=%0b cr=%h cc=%h len=%0d required all 0",
                               send_val, recv_rdy, cr, cc, send_len);
        end
        @(negedge clk); reset = 1'b0;
        send_elem(ONE, 2*ONE, 3*ONE, 4*ONE, 1'b0, 1'b1, 1'b0);
        get_result(0, gr, gc, gl, go, lat);
        checks++;
        if (gr !== 32'hFFFB_0000 || gc !== 32'h000A_0000 || gl !== LW'(1) || go !== 1'b0) begin
            errors++; $display("FAIL abort_done_after: cr=%h cc=%h len=%0d ovf=%0b required FFFB0000 000A0000 1 0",
                               gr, gc, gl, go);
        end
    endtask

    task automatic test_random();
        logic [31:0] xar, xac, xbr, xbc, er, ec;
        logic        xcj, xl, xae, eop, eovf;
        int          elen;
        m_r = '0; m_c = '0; m_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            xar = $urandom; xac = $urandom; xbr = $urandom; xbc = $urandom;
            xcj = 1'($urandom_range(0, 1));
            xl  = ($urandom_range(0, 2) == 0) || (i == 59);
            xae = ($urandom_range(0, 3) != 0);
            send_elem(xar, xac, xbr, xbc, xcj, xl, xae);
            model_elem(xar, xac, xbr, xbc, xcj, xl, xae, eop, er, ec, elen, eovf);
            if (eop) begin
                get_result($urandom_range(0, 3), gr, gc, gl, go, lat);
                checks++;
                if (gr !== er || gc !== ec || gl !== LW'(elen) || go !== eovf) begin
                    errors++;
                    $display("FAIL random[%0d]: cr=%h cc=%h len=%0d ovf=%0b required %h %h %0d %0b",
                             i, gr, gc, gl, go, er, ec, elen, eovf);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_plain_mult();
        test_conj();
        test_mac();
        test_backpressure();
        test_overflow();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
